// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: register IDs, word types and instruction codes.
package y86_pkg;

  typedef logic [3:0]  reg_id_t;
  typedef logic [63:0] word_t;

  localparam reg_id_t REG_NONE = 4'hF;
  localparam reg_id_t REG_RSP  = 4'h4;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  function automatic logic is_reg(input reg_id_t id);
    return id != REG_NONE;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits: set on issue, cleared on write-back, set wins on a tie.
module reg_scoreboard
  import y86_pkg::*;
#(
  parameter int unsigned NREG = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [3:0]      issue_dstA,
  input  logic [3:0]      issue_dstB,
  input  logic            weA,
  input  logic            weB,
  input  logic [3:0]      dstA,
  input  logic [3:0]      dstB,
  output logic [NREG-1:0] pend
);

  logic [NREG-1:0] pend_d, pend_q;

  always_comb begin
    pend_d = pend_q;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (weA && dstA == 4'(i)) pend_d[i] = 1'b0;
      if (weB && dstB == 4'(i)) pend_d[i] = 1'b0;
      // Sets come last so a newer producer outranks a retiring one.
      if (issue_valid && issue_dstA == 4'(i)) pend_d[i] = 1'b1;
      if (issue_valid && issue_dstB == 4'(i)) pend_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/register_file.sv
// Y86-64 architectural register file: two bypassed combinational reads, two writes,
// and a pending scoreboard that drives the decode stall.
module register_file
  import y86_pkg::*;
#(
  parameter int unsigned NREG = 15,
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      srcA,
  input  logic [3:0]      srcB,
  output logic [XLEN-1:0] valA,
  output logic [XLEN-1:0] valB,
  output logic            stall,
  input  logic            issue_valid,
  input  logic [3:0]      issue_dstA,
  input  logic [3:0]      issue_dstB,
  input  logic            wb_valid,
  input  logic [3:0]      dstA,
  input  logic [3:0]      dstB,
  input  logic [XLEN-1:0] dataA,
  input  logic [XLEN-1:0] dataB
);

  logic [XLEN-1:0] regs_d [NREG];
  logic [XLEN-1:0] regs_q [NREG];
  logic            weA, weB;
  logic            bypA, bypB;
  logic [NREG-1:0] pend;
  logic [15:0]     pend_ext;

  assign weA = wb_valid && is_reg(dstA);
  assign weB = wb_valid && is_reg(dstB);

  always_comb begin
    regs_d = regs_q;
    if (weA) regs_d[dstA] = dataA;
    // Port B last: popq %rsp must land valM, not valE.
    if (weB) regs_d[dstB] = dataB;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign bypA = (weB && dstB == srcA) || (weA && dstA == srcA);
  assign bypB = (weB && dstB == srcB) || (weA && dstA == srcB);

  always_comb begin
    valA = '0;
    if (!rst_n || !is_reg(srcA))  valA = '0;
    else if (weB && dstB == srcA) valA = dataB;
    else if (weA && dstA == srcA) valA = dataA;
    else                          valA = regs_q[srcA];
  end

  always_comb begin
    valB = '0;
    if (!rst_n || !is_reg(srcB))  valB = '0;
    else if (weB && dstB == srcB) valB = dataB;
    else if (weA && dstA == srcB) valB = dataA;
    else                          valB = regs_q[srcB];
  end

  reg_scoreboard #(
    .NREG(NREG)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_valid(issue_valid),
    .issue_dstA (issue_dstA),
    .issue_dstB (issue_dstB),
    .weA        (weA),
    .weB        (weB),
    .dstA       (dstA),
    .dstB       (dstB),
    .pend       (pend)
  );

  // Pad to 16 so ID 15 indexes a constant zero.
  assign pend_ext = 16'(pend);

  assign stall = rst_n && ((is_reg(srcA) && pend_ext[srcA] && !bypA) ||
                           (is_reg(srcB) && pend_ext[srcB] && !bypB));

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed scenarios plus randomized traffic against an array model.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  srcA, srcB, issue_dstA, issue_dstB, dstA, dstB;
  logic [63:0] valA, valB, dataA, dataB;
  logic        stall, issue_valid, wb_valid;

  int n_cmp = 0;
  int n_fail = 0;

  logic [63:0] m_reg [15];
  bit          m_pend [15];

  register_file #(
    .NREG(15),
    .XLEN(64)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .srcA       (srcA),
    .srcB       (srcB),
    .valA       (valA),
    .valB       (valB),
    .stall      (stall),
    .issue_valid(issue_valid),
    .issue_dstA (issue_dstA),
    .issue_dstB (issue_dstB),
    .wb_valid   (wb_valid),
    .dstA       (dstA),
    .dstB       (dstB),
    .dataA      (dataA),
    .dataB      (dataB)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] exp_val(input logic [3:0] s);
    if (s == 4'hF) return 64'd0;
    if (wb_valid && dstB == s) return dataB;
    if (wb_valid && dstA == s) return dataA;
    return m_reg[s];
  endfunction

  function automatic bit covered(input logic [3:0] s);
    return wb_valid && (dstA == s || dstB == s);
  endfunction

  function automatic logic exp_stall();
    bit sa, sb;
    sa = (srcA != 4'hF) && m_pend[srcA] && !covered(srcA);
    sb = (srcB != 4'hF) && m_pend[srcB] && !covered(srcB);
    return sa || sb;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 15; i++) begin
      m_reg[i] = 64'd0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic drive_idle();
    srcA = 4'hF; srcB = 4'hF;
    issue_valid = 1'b0; issue_dstA = 4'hF; issue_dstB = 4'hF;
    wb_valid = 1'b0; dstA = 4'hF; dstB = 4'hF;
    dataA = 64'd0; dataB = 64'd0;
  endtask

  // Applies the current inputs to the model, then crosses the edge.
  task automatic edge_step();
    if (wb_valid && dstA != 4'hF) begin
      m_reg[dstA] = dataA;
      m_pend[dstA] = 1'b0;
    end
    if (wb_valid && dstB != 4'hF) begin
      m_reg[dstB] = dataB;
      m_pend[dstB] = 1'b0;
    end
    if (issue_valid && issue_dstA != 4'hF) m_pend[issue_dstA] = 1'b1;
    if (issue_valid && issue_dstB != 4'hF) m_pend[issue_dstB] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    model_clear();
    wb_valid = 1'b1; dstA = 4'd3; dataA = 64'h77; srcA = 4'd3;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (valA !== 64'd0) begin
      n_fail++; $display("FAIL reset_out_valA: got %h want 0", valA);
    end
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      srcA = 4'(i); srcB = 4'(15 - i);
      #1;
      n_cmp++;
      if (valA !== 64'd0 || valB !== 64'd0 || stall !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_read id=%0d: got %h %h stall=%b want 0 0 0", i, valA, valB, stall);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_simple_write();
    drive_idle();
    srcA = 4'd3; wb_valid = 1'b1; dstA = 4'd3; dataA = 64'h1234;
    #2;
    n_cmp++;
    if (valA !== 64'h1234) begin
      n_fail++; $display("FAIL write_bypass: got %h want 1234", valA);
    end
    edge_step();
    drive_idle();
    srcA = 4'd3;
    #2;
    n_cmp++;
    if (valA !== 64'h1234) begin
      n_fail++; $display("FAIL write_array: got %h want 1234", valA);
    end
  endtask

  task automatic test_wb_gating();
    drive_idle();
    wb_valid = 1'b0; dstA = 4'd5; dataA = 64'hDEAD; srcA = 4'd5;
    #2;
    n_cmp++;
    if (valA !== 64'd0) begin
      n_fail++; $display("FAIL gate_no_bypass: got %h want 0", valA);
    end
    edge_step();
    drive_idle();
    wb_valid = 1'b1; dstB = 4'hF; dataB = 64'hBEEF;
    edge_step();
    drive_idle();
    for (int i = 0; i < 15; i++) begin
      srcA = 4'(i);
      #1;
      n_cmp++;
      if (valA !== m_reg[i]) begin
        n_fail++; $display("FAIL gate_regs id=%0d: got %h want %h", i, valA, m_reg[i]);
      end
    end
    n_cmp++;
    if (m_reg[5] !== 64'd0 || m_reg[3] !== 64'h1234) begin
      n_fail++; $display("FAIL gate_model: got %h %h want 0 1234", m_reg[5], m_reg[3]);
    end
  endtask

  task automatic test_popq();
    drive_idle();
    wb_valid = 1'b1; dstA = 4'd4; dataA = 64'h100; dstB = 4'd4; dataB = 64'h55;
    srcB = 4'd4;
    #2;
    n_cmp++;
    if (valB !== 64'h55) begin
      n_fail++; $display("FAIL popq_bypass: got %h want 55", valB);
    end
    edge_step();
    drive_idle();
    srcA = 4'd4;
    #2;
    n_cmp++;
    if (valA !== 64'h55) begin
      n_fail++; $display("FAIL popq_array: got %h want 55", valA);
    end
  endtask

  task automatic test_stall();
    drive_idle();
    issue_valid = 1'b1; issue_dstA = 4'd2;
    edge_step();
    drive_idle();
    srcA = 4'd2;
    #2;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL stall_set: got %b want 1", stall);
    end
    wb_valid = 1'b1; dstA = 4'd2; dataA = 64'd7;
    #1;
    n_cmp++;
    if (stall !== 1'b0 || valA !== 64'd7) begin
      n_fail++; $display("FAIL stall_bypass: got stall=%b val=%h want 0 7", stall, valA);
    end
    edge_step();
    drive_idle();
    srcA = 4'd2;
    #2;
    n_cmp++;
    if (stall !== 1'b0 || valA !== 64'd7) begin
      n_fail++; $display("FAIL stall_clear: got stall=%b val=%h want 0 7", stall, valA);
    end
  endtask

  task automatic test_set_wins();
    drive_idle();
    issue_valid = 1'b1; issue_dstB = 4'd6;
    wb_valid = 1'b1; dstA = 4'd6; dataA = 64'hA5;
    edge_step();
    drive_idle();
    srcA = 4'd6;
    #2;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL set_wins: got %b want 1", stall);
    end
    wb_valid = 1'b1; dstB = 4'd6; dataB = 64'hA6;
    edge_step();
    drive_idle();
  endtask

  task automatic test_reset_mid();
    drive_idle();
    wb_valid = 1'b1; dstA = 4'd1; dataA = 64'd9;
    issue_valid = 1'b1; issue_dstA = 4'd1;
    edge_step();
    drive_idle();
    srcA = 4'd1;
    #2;
    n_cmp++;
    if (valA !== 64'd9 || stall !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: got val=%h stall=%b want 9 1", valA, stall);
    end
    rst_n = 1'b0;
    model_clear();
    #1;
    n_cmp++;
    if (valA !== 64'd0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_during: got val=%h stall=%b want 0 0", valA, stall);
    end
    #2;
    rst_n = 1'b1;
    edge_step();
    n_cmp++;
    if (valA !== 64'd0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_after: got val=%h stall=%b want 0 0", valA, stall);
    end
  endtask

  task automatic test_random();
    logic [63:0] ea, eb;
    logic        es;
    for (int n = 0; n < 400; n++) begin
      srcA = 4'($urandom_range(0, 15));
      srcB = 4'($urandom_range(0, 15));
      issue_valid = 1'($urandom_range(0, 3) == 0);
      issue_dstA = 4'($urandom_range(0, 15));
      issue_dstB = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      wb_valid = 1'($urandom_range(0, 1));
      dstA = 4'($urandom_range(0, 15));
      dstB = ($urandom_range(0, 2) == 0) ? srcA : 4'($urandom_range(0, 15));
      dataA = {$urandom, $urandom};
      dataB = {$urandom, $urandom};
      #2;
      ea = exp_val(srcA);
      eb = exp_val(srcB);
      es = exp_stall();
      n_cmp++;
      if (valA !== ea || valB !== eb || stall !== es) begin
        n_fail++;
        $display("FAIL random[%0d] src=%0d/%0d: got %h %h stall=%b want %h %h stall=%b",
                 n, srcA, srcB, valA, valB, stall, ea, eb, es);
      end
      edge_step();
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_simple_write();
    test_wb_gating();
    test_popq();
    test_stall();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Architectural register file for the Y86-64 core: 15 × 64-bit registers (%rax..%r14, %rsp = 4), two combinational read ports for decode and two clocked write ports fed by the write-back stage's `dstA/dataA` and `dstB/dataB`. It also keeps a per-register pending scoreboard so decode can stall on sources whose write-back has not yet landed. Register ID 15 means "no register" on every port.

## Interface
- `NREG`, 15: number of architectural registers. ID 15 is reserved as "none".
- `XLEN`, 64: data width.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `srcA`, `srcB` input 4: read register IDs. 15 means no read.
- `valA`, `valB` output 64: read data.
- `stall` output 1: a source read this cycle is pending.
- `issue_valid` input 1: decode issues an instruction this cycle.
- `issue_dstA`, `issue_dstB` input 4: destinations of the issued instruction. 15 means none.
- `wb_valid` input 1: the write-back outputs are meaningful this cycle.
- `dstA`, `dstB` input 4: write-back destinations. 15 means none.
- `dataA`, `dataB` input 64: write-back data.

## Operation
- **Write enables.**
  - `weA = wb_valid && dstA != 15`.
  - `weB = wb_valid && dstB != 15`.
  - Without `wb_valid`, held (stale) write-back outputs must not cause writes.
- **Writes.** On the rising edge: `reg[dstA] <= dataA` if `weA`; `reg[dstB] <= dataB` if `weB`.
- **Same-register conflict.** If `weA && weB && dstA == dstB`, port B wins. This gives Y86 `popq %rsp` semantics: the destination gets `valM`, not `valE`.
- **Reads** are combinational.
  - `valX = 0` when `srcX == 15`.
  - Otherwise bypass: if `weB && dstB == srcX`, return `dataB`.
  - Else if `weA && dstA == srcX`, return `dataA`.
  - Else return `reg[srcX]`.
  - Bypass priority mirrors the write priority.
- **Scoreboard.** One pending bit per register, `pend[14:0]`.
  - Set: bits `issue_dstA` and `issue_dstB` (when ≠ 15) on an edge where `issue_valid=1`.
  - Clear: bits `dstA`/`dstB` on an edge where the corresponding write enable is 1.
  - Same register set and cleared on the same edge: set wins (newer producer).
- **Stall.** `stall = (srcA≠15 && pend[srcA] && !bypassA) || (srcB≠15 && pend[srcB] && !bypassB)`.
  - `bypassX` is true when the same-cycle write covers `srcX`.
  - The block does not gate `issue_valid` with `stall`; the caller must.
- **Reset (asynchronous, `rst_n=0`).**
  - All registers are cleared to 0 and all pending bits to 0.
  - Outputs while in reset: `valA=valB=0`, `stall=0`.
  - A write or issue coincident with reset assertion is lost.
  - Reset deasserting mid-stream leaves every register 0 and nothing pending.

## Timing
- Read latency: 0 cycles (combinational, including bypass).
- Write latency: 1 edge. A value written at edge N is visible from the register array after N, and via bypass during the cycle before N.
- Pending bit: visible the cycle after the issue edge; cleared the cycle after the write edge.
- No handshake back-pressure on write-back. Every valid write is accepted.

## Structure
- Shared package `y86_pkg` holds:
  - `REG_NONE = 4'hF` and `REG_RSP = 4'h4`;
  - the `reg_id_t` (4-bit) and `word_t` (64-bit) typedefs;
  - icode constants, shared with fetch, decode and write-back.
- One natural sub-module: `reg_scoreboard`, which holds the pending bits and the set/clear/priority logic. It takes the issue ports and write enables and returns `pend`. The storage and bypass logic stay in `register_file`.

## Test plan
- **Reset and simple write.** Reset, then read all IDs: every `valX=0` and `stall=0`. Write `dstA=3`, `dataA=0x1234`, `wb_valid=1`. In the same cycle `srcA=3` bypasses `0x1234`; the next cycle `reg[3]` reads `0x1234`.
- **`wb_valid` gating.** `wb_valid=0`, `dstA=5`, `dataA=0xDEAD`: `reg[5]` stays 0. `dstB=15`, `dataB=0xBEEF`, `wb_valid=1`: no register changes.
- **popq conflict.** `dstA=4`/`dataA=0x100` and `dstB=4`/`dataB=0x55` on the same edge: `reg[4]=0x55`, and the same-cycle bypass on `srcB=4` also returns `0x55`.
- **Scoreboard stall.** Issue `issue_dstA=2`. Next cycle `srcA=2` gives `stall=1`. A write-back with `dstA=2`, `dataA=7` drops `stall` to 0 in the write cycle with `valA=7`; the pending bit is clear afterwards.
- **Set wins over clear.** Issue with `issue_dstB=6` and write back `dstA=6` on the same edge: `pend[6]` stays 1, so `stall=1` when `srcA=6` next cycle.
- **Reset mid-operation.** With `reg[1]=9` and `pend[1]=1`, pulse `rst_n` low between edges: `valA` for `srcA=1` drops to 0 immediately, `stall=0`, and both hold after release.
